round_pipe: RTL and testbench

ROUND_PIPE -- requirements
Module: round_pipe

---
 rtl/round_pipe.sv | 145 ++++++++++++++
 tb/tb_round_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : round_pipe
// Description : Two-stage IEEE-style rounding pipeline with valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
module round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [EXP_W-1:0] exp,
    input  logic [MAN_W+2:0] mantis,
    input  logic             loss,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] mantis_out,
    output logic             inexact,
    output logic             overflow
);

    localparam logic [EXP_W-1:0] c_exp_ones = '1;
    localparam logic [EXP_W-1:0] c_exp_one  = {{(EXP_W-1){1'b0}}, 1'b1};

    // Stage 1: operand plus precomputed increment decision
    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [MAN_W:0]   r_s1_sig;
    logic             r_s1_inc;
    logic             r_s1_inexact;

    // Stage 2: final result, drives the outputs directly
    logic             r_s2_valid;
    logic             r_s2_sign;
    logic [EXP_W-1:0] r_s2_exp;
    logic [MAN_W-1:0] r_s2_man;
    logic             r_s2_inexact;
    logic             r_s2_overflow;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_any;
    logic             w_special;
    logic             w_inc;
    logic [MAN_W+1:0] w_sum;
    logic [EXP_W-1:0] w_exp_inc;
    logic [EXP_W-1:0] w_exp_n;
    logic [MAN_W-1:0] w_man_n;
    logic             w_ovf_n;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    // Held low throughout reset even though the pipeline flops are already clear
    assign in_ready  = rst_n && w_s1_load;

    assign w_any     = mantis[1] | mantis[0] | loss;
    assign w_special = (exp == c_exp_ones);

    always_comb begin
        w_inc = 1'b0;
        case (mode)
            2'b00:   w_inc = mantis[1] & (mantis[0] | loss | mantis[2]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = w_any & !sign;
            default: w_inc = w_any & sign;
        endcase
        if (w_special) begin
            w_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_sig     <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= sign;
                r_s1_exp     <= exp;
                r_s1_sig     <= mantis[MAN_W+2:2];
                r_s1_inc     <= w_inc;
                r_s1_inexact <= w_any & !w_special;
            end
        end
    end

    assign w_sum     = {1'b0, r_s1_sig} + {{(MAN_W+1){1'b0}}, r_s1_inc};
    assign w_exp_inc = r_s1_exp + c_exp_one;

    always_comb begin
        w_exp_n = r_s1_exp;
        w_man_n = w_sum[MAN_W-1:0];
        w_ovf_n = 1'b0;
        if (r_s1_exp == '0) begin
            // Subnormal: an increment reaching the hidden bit promotes to exp 1
            w_exp_n = {{(EXP_W-1){1'b0}}, w_sum[MAN_W]};
        end else if (w_sum[MAN_W+1]) begin
            w_exp_n = w_exp_inc;
            w_man_n = '0;
            w_ovf_n = (w_exp_inc == c_exp_ones);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_sign     <= 1'b0;
            r_s2_exp      <= '0;
            r_s2_man      <= '0;
            r_s2_inexact  <= 1'b0;
            r_s2_overflow <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign     <= r_s1_sign;
                r_s2_exp      <= w_exp_n;
                r_s2_man      <= w_man_n;
                r_s2_inexact  <= r_s1_inexact;
                r_s2_overflow <= w_ovf_n;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign sign_out   = r_s2_sign;
    assign exp_out    = r_s2_exp;
    assign mantis_out = r_s2_man;
    assign inexact    = r_s2_inexact;
    assign overflow   = r_s2_overflow;

endmodule
`default_nettype wire

// File: tb/tb_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_pipe
// Description : Directed vector bench for round_pipe (EXP_W=8, MAN_W=23).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [25:0] mantis;
        logic        loss;
        logic [1:0]  mode;
        logic [7:0]  exp_e;
        logic [22:0] man_e;
        logic        inx_e;
        logic        ovf_e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sign = 1'b0;
    logic [EXP_W-1:0] exp = '0;
    logic [MAN_W+2:0] mantis = '0;
    logic             loss = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             sign_out;
    logic [EXP_W-1:0] exp_out;
    logic [MAN_W-1:0] mantis_out;
    logic             inexact;
    logic             overflow;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[15];

    round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp), .mantis(mantis), .loss(loss), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mantis_out(mantis_out),
        .inexact(inexact), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        sign   = v.sign;
        exp    = v.exp;
        mantis = v.mantis;
        loss   = v.loss;
        mode   = v.mode;
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, ".valid"},    32'(out_valid),  32'd1);
        chk({tag, ".sign"},     32'(sign_out),   32'(v.sign));
        chk({tag, ".exp"},      32'(exp_out),    32'(v.exp_e));
        chk({tag, ".mantis"},   32'(mantis_out), 32'(v.man_e));
        chk({tag, ".inexact"},  32'(inexact),    32'(v.inx_e));
        chk({tag, ".overflow"}, 32'(overflow),   32'(v.ovf_e));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid),  32'd0);
        chk({tag, ".sign_out"},  32'(sign_out),   32'd0);
        chk({tag, ".exp_out"},   32'(exp_out),    32'd0);
        chk({tag, ".mantis"},    32'(mantis_out), 32'd0);
        chk({tag, ".inexact"},   32'(inexact),    32'd0);
        chk({tag, ".overflow"},  32'(overflow),   32'd0);
        chk({tag, ".in_ready"},  32'(in_ready),   32'd0);
    endtask

    initial begin
        // sign, exp, {hidden,frac,G,R}, loss, mode -> exp, frac, inexact, overflow
        vecs[0]  = '{1'b0, 8'h80, {1'b1, 23'h000001, 2'b10}, 1'b0, 2'd0, 8'h80, 23'h000002, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h80, {1'b1, 23'h7FFFFF, 2'b10}, 1'b0, 2'd0, 8'h81, 23'h000000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'hFE, {1'b1, 23'h7FFFFF, 2'b10}, 1'b0, 2'd0, 8'hFF, 23'h000000, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'hFE, {1'b1, 23'h7FFFFF, 2'b10}, 1'b0, 2'd1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, {1'b0, 23'h7FFFFF, 2'b11}, 1'b0, 2'd2, 8'h01, 23'h000000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, {1'b0, 23'h7FFFFF, 2'b11}, 1'b0, 2'd2, 8'h00, 23'h7FFFFF, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h80, {1'b1, 23'h000002, 2'b10}, 1'b0, 2'd0, 8'h80, 23'h000002, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h80, {1'b1, 23'h000002, 2'b10}, 1'b1, 2'd0, 8'h80, 23'h000003, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h7F, {1'b1, 23'h123456, 2'b00}, 1'b0, 2'd3, 8'h7F, 23'h123456, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h7F, {1'b1, 23'h123456, 2'b00}, 1'b1, 2'd3, 8'h7F, 23'h123457, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h7F, {1'b1, 23'h123456, 2'b01}, 1'b0, 2'd3, 8'h7F, 23'h123456, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'hFF, {1'b1, 23'h400001, 2'b11}, 1'b1, 2'd0, 8'hFF, 23'h400001, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h00, {1'b0, 23'h000010, 2'b11}, 1'b0, 2'd0, 8'h00, 23'h000011, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'hFE, {1'b1, 23'h7FFFFF, 2'b01}, 1'b0, 2'd3, 8'hFF, 23'h000000, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h10, {1'b1, 23'h7FFFFF, 2'b11}, 1'b1, 2'd1, 8'h10, 23'h7FFFFF, 1'b1, 1'b0};

        #2;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);

        // Single operands, latency check on each
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d.early_valid", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            chk_result($sformatf("v%0d", i), vecs[i]);
        end

        // Back-to-back throughput
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            if (i >= 1) chk_result($sformatf("stream%0d", i - 1), vecs[i - 1]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk_result("stream3", vecs[3]);
        @(negedge clk);
        chk("stream.drain", 32'(out_valid), 32'd0);

        // Backpressure: two accepted, third stalls, results in order
        out_ready = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        chk("bp.a_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(vecs[1]);
        chk("bp.b_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(vecs[2]);
        chk("bp.c_stall", 32'(in_ready), 32'd0);
        chk_result("bp.hold0", vecs[0]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp.c_stall_more", 32'(in_ready), 32'd0);
            chk_result("bp.hold", vecs[0]);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_result("bp.second", vecs[1]);
        @(negedge clk);
        chk_result("bp.third", vecs[2]);
        @(negedge clk);
        chk("bp.empty", 32'(out_valid), 32'd0);

        // Reset with both stages full, asserted between clock edges
        out_ready = 1'b0;
        drive(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[4]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst.full_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst.async");
        @(negedge clk);
        chk_zero_outputs("rst.held");
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst.flushed", 32'(out_valid), 32'd0);
        drive(vecs[5]);
        in_valid = 1'b1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst.early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk_result("rst.first", vecs[5]);
        @(negedge clk);
        chk("rst.drain", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
